// File: rtl/cpu_exec_ctrl_if.sv
// rtl/cpu_exec_ctrl_if.sv - instruction memory write port between the command sequencer and IMEM
interface cpu_exec_ctrl_if #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 8
);
  logic [NB_INSTRUCTION-1:0]  o_imem_data;
  logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr;
  logic [1:0]                 o_imem_wsize;
  logic                       o_imem_wen;

  modport master (
    output o_imem_data,
    output o_imem_waddr,
    output o_imem_wsize,
    output o_imem_wen
  );

  modport slave (
    input o_imem_data,
    input o_imem_waddr,
    input o_imem_wsize,
    input o_imem_wen
  );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// rtl/cpu_exec_ctrl.sv - host command sequencer: IMEM loader, run/step/halt control of the core
module cpu_exec_ctrl #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int NB_UART_DATA    = 8
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic [NB_UART_DATA-1:0] i_rx_data,
  input  logic                    i_rx_done,
  input  logic                    i_halt,
  cpu_exec_ctrl_if.master         imem,
  output logic                    o_cpu_en,
  output logic                    o_load_done,
  output logic                    o_err,
  output logic                    o_busy
);

  localparam int WPB   = NB_INSTRUCTION / 8;
  localparam int CNT_W = $clog2(WPB + 1);

  localparam logic [NB_UART_DATA-1:0] CMD_L = NB_UART_DATA'(8'h4C);
  localparam logic [NB_UART_DATA-1:0] CMD_R = NB_UART_DATA'(8'h52);
  localparam logic [NB_UART_DATA-1:0] CMD_S = NB_UART_DATA'(8'h53);
  localparam logic [NB_UART_DATA-1:0] CMD_H = NB_UART_DATA'(8'h48);

  typedef enum logic [1:0] {IDLE, LEN, DATA, RUN} state_t;

  state_t                    state;
  logic [NB_UART_DATA-1:0]   n_words;
  logic [NB_UART_DATA-1:0]   word_idx;
  logic [CNT_W-1:0]          byte_cnt;
  logic [NB_INSTRUCTION-1:0] buffer;
  logic                      finishing;
  logic [NB_INSTRUCTION-1:0] shifted;

  // New byte enters at the top; after WPB bytes the first one sits in bits [7:0].
  assign shifted = (NB_INSTRUCTION'(i_rx_data) << (NB_INSTRUCTION - NB_UART_DATA))
                 | (buffer >> NB_UART_DATA);

  assign imem.o_imem_wsize = 2'b10;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state             <= IDLE;
      n_words           <= '0;
      word_idx          <= '0;
      byte_cnt          <= '0;
      buffer            <= '0;
      finishing         <= 1'b0;
      imem.o_imem_data  <= '0;
      imem.o_imem_waddr <= '0;
      imem.o_imem_wen   <= 1'b0;
      o_cpu_en          <= 1'b0;
      o_load_done       <= 1'b0;
      o_err             <= 1'b0;
      o_busy            <= 1'b0;
    end else begin
      imem.o_imem_wen <= 1'b0;
      o_load_done     <= 1'b0;
      o_err           <= 1'b0;
      o_cpu_en        <= 1'b0;

      case (state)
        IDLE: begin
          if (i_rx_done) begin
            case (i_rx_data)
              CMD_L: begin
                state  <= LEN;
                o_busy <= 1'b1;
              end
              CMD_R: begin
                state    <= RUN;
                o_busy   <= 1'b1;
                o_cpu_en <= 1'b1;
              end
              CMD_S:   o_cpu_en <= 1'b1;
              CMD_H:   ;
              default: o_err <= 1'b1;
            endcase
          end
        end

        LEN: begin
          if (i_rx_done) begin
            n_words  <= i_rx_data;
            word_idx <= '0;
            byte_cnt <= '0;
            buffer   <= '0;
            if (i_rx_data == '0) begin
              state       <= IDLE;
              o_busy      <= 1'b0;
              o_load_done <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          // The last word's write cycle only closes the load; bytes are not consumed then.
          if (finishing) begin
            finishing   <= 1'b0;
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_load_done <= 1'b1;
          end else if (i_rx_done) begin
            buffer <= shifted;
            if (byte_cnt == CNT_W'(WPB - 1)) begin
              imem.o_imem_data  <= shifted;
              imem.o_imem_waddr <= IMEM_ADDR_WIDTH'({word_idx, 2'b00});
              imem.o_imem_wen   <= 1'b1;
              word_idx          <= word_idx + NB_UART_DATA'(1);
              byte_cnt          <= '0;
              finishing         <= ((word_idx + NB_UART_DATA'(1)) == n_words);
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end

        RUN: begin
          if (i_halt || (i_rx_done && i_rx_data == CMD_H)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            o_cpu_en <= 1'b1;
          end
          if (i_rx_done && i_rx_data != CMD_H) begin
            o_err <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
